// File: rtl/im2col_fetch.sv
// im2col row fetcher: issues per-lane reads for one kernel row per request and
// buffers the returned pixels in a 4-deep FIFO. Optional zero padding: IM2COL_FETCH_ZERO_PAD_EN.
module im2col_fetch #(
    parameter int LANES  = 3,
    parameter int DATA_W = 8,
    parameter int AX_W   = 8,
    parameter int AY_W   = 8
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iReqValid,
    output logic                          oReqReady,
    input  logic [LANES*AX_W-1:0]         iReqXAddr,
    input  logic [AY_W-1:0]               iReqYAddr,
    input  logic [LANES-1:0]              iReqDv,
    input  logic                          iReqDone,
    input  logic [AX_W-1:0]               iImgWidth,
    output logic [LANES-1:0]              oMemRdEn,
    output logic [LANES*(AY_W+AX_W)-1:0]  oMemAddr,
    input  logic [LANES*DATA_W-1:0]       iMemRdData,
    output logic                          oPixValid,
    input  logic                          iPixReady,
    output logic [LANES*DATA_W-1:0]       oPixData,
    output logic                          oPixLast,
    output logic                          oWinDone
);

    localparam int AW = AY_W + AX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [2:0]              r_count;
    logic [1:0]              r_wr_ptr;
    logic [1:0]              r_rd_ptr;
    logic                    r_inflight;
    logic [LANES-1:0]        r_keep;
    logic                    r_done_d;
    logic [LANES*DATA_W-1:0] r_fifo_data [4];
    logic [3:0]              r_fifo_last;

    logic [AX_W-1:0]         w_x [LANES];
    logic [LANES-1:0]        w_keep;
    logic [LANES*DATA_W-1:0] w_push_data;
    logic [2:0]              w_occ;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_win_done;

    // In-flight reads count against capacity so a returning read always finds a free slot.
    assign w_occ     = r_count + {2'b00, r_inflight};
    assign oReqReady = !iRst && (w_occ < 3'd4) && (r_state != S_DRAIN);
    assign w_accept  = iReqValid && oReqReady;
    assign w_push    = r_inflight;
    assign oPixValid = !iRst && (r_count != 3'd0);
    assign w_pop     = oPixValid && iPixReady;
    assign oPixData  = oPixValid ? r_fifo_data[r_rd_ptr] : '0;
    assign oPixLast  = oPixValid ? r_fifo_last[r_rd_ptr] : 1'b0;
    assign oWinDone  = w_win_done && !iRst;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_x[gi] = iReqXAddr[gi*AX_W +: AX_W];
`ifdef IM2COL_FETCH_ZERO_PAD_EN
            // Out-of-image columns read nothing and are returned as zero.
            assign w_keep[gi] = iReqDv[gi] && (w_x[gi] < iImgWidth);
`else
            assign w_keep[gi] = iReqDv[gi];
`endif
            assign oMemAddr[gi*AW +: AW]         = {iReqYAddr, w_x[gi]};
            assign oMemRdEn[gi]                  = w_accept && w_keep[gi];
            assign w_push_data[gi*DATA_W +: DATA_W] =
                r_keep[gi] ? iMemRdData[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

`ifndef IM2COL_FETCH_ZERO_PAD_EN
    logic w_unused_width;
    assign w_unused_width = ^iImgWidth;
`endif

    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_last[r_wr_ptr] <= r_done_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_count    <= 3'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_inflight <= 1'b0;
            r_keep     <= '0;
            r_done_d   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_accept;
            if (w_accept) begin
                r_keep   <= w_keep;
                r_done_d <= iReqDone;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_win_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = iReqDone ? S_DRAIN : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_accept && iReqDone) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_count == 3'd0) && !r_inflight) begin
                    w_state_next = S_IDLE;
                    w_win_done   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_im2col_fetch.sv
// Bench for im2col_fetch: directed and random requests against a queue-based
// reference model and a 1-cycle-latency memory model.
module tb_im2col_fetch;

    localparam int LANES  = 3;
    localparam int DATA_W = 8;
    localparam int AX_W   = 8;
    localparam int AY_W   = 8;
    localparam int AW     = AY_W + AX_W;

    logic                          iClk;
    logic                          iRst;
    logic                          iReqValid;
    logic                          oReqReady;
    logic [LANES*AX_W-1:0]         iReqXAddr;
    logic [AY_W-1:0]               iReqYAddr;
    logic [LANES-1:0]              iReqDv;
    logic                          iReqDone;
    logic [AX_W-1:0]               iImgWidth;
    logic [LANES-1:0]              oMemRdEn;
    logic [LANES*AW-1:0]           oMemAddr;
    logic [LANES*DATA_W-1:0]       iMemRdData;
    logic                          oPixValid;
    logic                          iPixReady;
    logic [LANES*DATA_W-1:0]       oPixData;
    logic                          oPixLast;
    logic                          oWinDone;

    im2col_fetch #(
        .LANES(LANES), .DATA_W(DATA_W), .AX_W(AX_W), .AY_W(AY_W)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .iReqValid(iReqValid), .oReqReady(oReqReady),
        .iReqXAddr(iReqXAddr), .iReqYAddr(iReqYAddr),
        .iReqDv(iReqDv), .iReqDone(iReqDone), .iImgWidth(iImgWidth),
        .oMemRdEn(oMemRdEn), .oMemAddr(oMemAddr), .iMemRdData(iMemRdData),
        .oPixValid(oPixValid), .iPixReady(iPixReady),
        .oPixData(oPixData), .oPixLast(oPixLast), .oWinDone(oWinDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic logic [DATA_W-1:0] pix(input logic [AY_W-1:0] y, input logic [AX_W-1:0] x);
        return (y * 8'd29) ^ (x * 8'd13) ^ 8'h5A;
    endfunction

    // Memory: 1-cycle read latency; unread lanes return a junk marker.
    always @(posedge iClk) begin
        for (int l = 0; l < LANES; l++) begin
            if (oMemRdEn[l])
                iMemRdData[l*DATA_W +: DATA_W] <= pix(oMemAddr[l*AW+AX_W +: AY_W], oMemAddr[l*AW +: AX_W]);
            else
                iMemRdData[l*DATA_W +: DATA_W] <= 8'hEE;
        end
    end

    typedef struct packed {
        logic [LANES*DATA_W-1:0] d;
        logic                    last;
    } beat_t;

    beat_t q[$];
    bit    drain_pending;
    int    n_checks = 0;
    int    n_fails  = 0;
    bit    acc_flag, sv_flag, wd_flag, s_ready;
    logic [LANES-1:0]        s_rden;
    logic [LANES*AW-1:0]     s_addr;
    logic [LANES*DATA_W-1:0] s_pix;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lane_read(input logic dv, input logic [AX_W-1:0] x, input logic [AX_W-1:0] w);
`ifdef IM2COL_FETCH_ZERO_PAD_EN
        return dv && (x < w);
`else
        return dv && (w == w);
`endif
    endfunction

    function automatic beat_t model_beat(input logic [LANES*AX_W-1:0] x, input logic [AY_W-1:0] y,
                                         input logic [LANES-1:0] dv, input logic done, input logic [AX_W-1:0] w);
        beat_t b;
        b.last = done;
        b.d    = '0;
        for (int l = 0; l < LANES; l++)
            if (lane_read(dv[l], x[l*AX_W +: AX_W], w))
                b.d[l*DATA_W +: DATA_W] = pix(y, x[l*AX_W +: AX_W]);
        return b;
    endfunction

    function automatic logic [LANES-1:0] model_rden(input logic [LANES*AX_W-1:0] x, input logic [LANES-1:0] dv,
                                                    input logic [AX_W-1:0] w);
        logic [LANES-1:0] r;
        for (int l = 0; l < LANES; l++) r[l] = lane_read(dv[l], x[l*AX_W +: AX_W], w);
        return r;
    endfunction

    function automatic logic [LANES*AW-1:0] model_addr(input logic [LANES*AX_W-1:0] x, input logic [AY_W-1:0] y);
        logic [LANES*AW-1:0] a;
        for (int l = 0; l < LANES; l++) a[l*AW +: AW] = {y, x[l*AX_W +: AX_W]};
        return a;
    endfunction

    function automatic logic [LANES*AX_W-1:0] rand_x(input int maxv);
        logic [LANES*AX_W-1:0] x;
        for (int l = 0; l < LANES; l++) x[l*AX_W +: AX_W] = AX_W'($urandom_range(0, maxv));
        return x;
    endfunction

    // One clock cycle: drive, sample after settling, check against the model.
    task automatic step(input logic v, input logic [LANES*AX_W-1:0] x, input logic [AY_W-1:0] y,
                        input logic [LANES-1:0] dv, input logic done, input logic pr);
        bit    exp_ready, exp_wd;
        beat_t b;
        @(negedge iClk);
        iReqValid = v; iReqXAddr = x; iReqYAddr = y; iReqDv = dv; iReqDone = done; iPixReady = pr;
        #1;
        exp_ready = !drain_pending && (q.size() < 4);
        exp_wd    = drain_pending && (q.size() == 0);
        if (exp_wd) drain_pending = 1'b0;
        check("req_ready", 64'(oReqReady), 64'(exp_ready));
        check("win_done", 64'(oWinDone), 64'(exp_wd));
        acc_flag = v && oReqReady;
        s_ready  = oReqReady;
        s_rden   = oMemRdEn;
        s_addr   = oMemAddr;
        sv_flag  = oPixValid;
        wd_flag  = oWinDone;
        check("mem_rden", 64'(oMemRdEn), acc_flag ? 64'(model_rden(x, dv, iImgWidth)) : 64'd0);
        if (oPixValid && pr) begin
            if (q.size() == 0) begin
                check("pop_empty", 64'd1, 64'd0);
            end else begin
                b = q.pop_front();
                s_pix = oPixData;
                check("pix_data", 64'(oPixData), 64'(b.d));
                check("pix_last", 64'(oPixLast), 64'(b.last));
            end
        end
        if (acc_flag) begin
            check("mem_addr", 64'(oMemAddr), 64'(model_addr(x, y)));
            q.push_back(model_beat(x, y, dv, done, iImgWidth));
            if (done) drain_pending = 1'b1;
        end
    endtask

    task automatic idle(input logic pr);
        step(1'b0, '0, '0, '0, 1'b0, pr);
    endtask

    // prm: 0 = sink stalled, 1 = sink ready, 2 = random sink
    task automatic send(input logic [LANES*AX_W-1:0] x, input logic [AY_W-1:0] y,
                        input logic [LANES-1:0] dv, input logic done, input int prm);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b1, x, y, dv, done, (prm == 2) ? 1'($urandom_range(0, 1)) : 1'(prm));
            got = acc_flag;
        end
        check("send_accept", 64'(got), 64'd1);
    endtask

    task automatic run_until_done(input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            idle(1'b1);
            seen = wd_flag;
        end
        check("win_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst = 1'b1; iReqValid = 1'b1; iReqDv = '1; iPixReady = 1'b1;
        #1;
        check("rst_ready", 64'(oReqReady), 64'd0);
        check("rst_rden", 64'(oMemRdEn), 64'd0);
        check("rst_valid", 64'(oPixValid), 64'd0);
        check("rst_data", 64'(oPixData), 64'd0);
        check("rst_last", 64'(oPixLast), 64'd0);
        check("rst_windone", 64'(oWinDone), 64'd0);
        q.delete();
        drain_pending = 1'b0;
        @(negedge iClk);
        iRst = 1'b0; iReqValid = 1'b0; iReqDv = '0;
    endtask

    initial begin
        int cnt;
        bit got;
        logic [LANES*AX_W-1:0] x5;
        iRst = 1'b1; iReqValid = 1'b0; iReqXAddr = '0; iReqYAddr = '0; iReqDv = '0;
        iReqDone = 1'b0; iImgWidth = 8'd255; iPixReady = 1'b0;
        drain_pending = 1'b0;
        s_pix = '0;
        do_reset();

        // Basic single-row window
        step(1'b1, {8'd2, 8'd1, 8'd0}, 8'd5, 3'b111, 1'b1, 1'b1);
        check("basic_accept", 64'(acc_flag), 64'd1);
        check("basic_addr", 64'(s_addr), 64'h0502_0501_0500);
        idle(1'b1);
        check("basic_lat1", 64'(sv_flag), 64'd0);
        idle(1'b1);
        check("basic_lat2", 64'(sv_flag), 64'd1);
        check("basic_data", 64'(s_pix), 64'({pix(8'd5, 8'd2), pix(8'd5, 8'd1), pix(8'd5, 8'd0)}));
        run_until_done(5);

        // Lane mask
        send(rand_x(200), 8'($urandom), 3'b101, 1'b1, 1);
        check("mask_rden", 64'(s_rden), 64'b101);
        run_until_done(6);
        check("mask_lane1", 64'(s_pix[15:8]), 64'd0);

        // Backpressure: only four requests fit
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rand_x(255), 8'($urandom), 3'b111, 1'b0, 1'b0);
            cnt += int'(acc_flag);
        end
        check("bp_accepted", 64'(cnt), 64'd4);
        idle(1'b0);
        check("bp_ready_low", 64'(s_ready), 64'd0);
        x5 = rand_x(255);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, x5, 8'd77, 3'b111, 1'b1, 1'b1);
            got = acc_flag;
        end
        check("bp_fifth_accept", 64'(got), 64'd1);
        run_until_done(12);

        // Three-row window with a jittery sink
        for (int r = 0; r < 3; r++) send(rand_x(255), 8'(r + 10), 3'b111, r == 2, 2);
        run_until_done(20);

        // Padding at the right image edge
        iImgWidth = 8'd4;
        send({8'd4, 8'd3, 8'd2}, 8'd9, 3'b111, 1'b1, 1);
`ifdef IM2COL_FETCH_ZERO_PAD_EN
        check("pad_rden", 64'(s_rden), 64'b011);
        run_until_done(6);
        check("pad_lane2", 64'(s_pix[23:16]), 64'd0);
`else
        check("pad_rden", 64'(s_rden), 64'b111);
        run_until_done(6);
        check("pad_lane2", 64'(s_pix[23:16]), 64'(pix(8'd9, 8'd4)));
`endif
        iImgWidth = 8'd255;

        // Reset with two beats buffered in DRAIN
        send(rand_x(255), 8'd20, 3'b111, 1'b0, 0);
        send(rand_x(255), 8'd21, 3'b111, 1'b1, 0);
        idle(1'b0);
        idle(1'b0);
        check("pre_rst_valid", 64'(sv_flag), 64'd1);
        do_reset();
        idle(1'b1);
        check("post_rst_valid", 64'(sv_flag), 64'd0);
        step(1'b1, rand_x(255), 8'd22, 3'b110, 1'b1, 1'b1);
        check("post_rst_accept", 64'(acc_flag), 64'd1);
        run_until_done(6);

        // Random windows
        for (int w = 0; w < 8; w++) begin
            int rows = $urandom_range(1, 4);
            iImgWidth = 8'($urandom_range(1, 255));
            for (int r = 0; r < rows; r++)
                send(rand_x(255), 8'($urandom), 3'($urandom), r == rows - 1, 2);
            run_until_done(20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
